// File: rtl/mc_sequencer.sv
// Multi-cycle phase controller for miniRV: FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
// Optional handshake watchdog enabled by defining SEQ_TIMEOUT_EN.
module mc_sequencer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_wen,
    input  logic             ins_illegal,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic             rf_wen_in,
    output logic             dram_req,
    output logic             dram_we,
    input  logic             dram_ack,
    output logic             rf_wen,
    output logic             pc_wen,
    output logic [2:0]       phase,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mc_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

`ifdef SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic              waiting;

    // Counter is zero in every non-waiting state, so it is already clear on entry to FETCH/MEM.
    assign waiting = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dram_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
`ifdef SEQ_TIMEOUT_EN
        fault_d   = fault_q;
        wait_d    = waiting ? wait_q + 1'b1 : '0;
`endif
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
`endif
            end
            S_DECODE: state_d = ins_illegal ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (mem_rd || mem_wr) ? S_MEM : S_WB;
            S_MEM: begin
                if (dram_ack) begin
                    state_d = S_WB;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
`endif
            end
            S_WB: begin
                retired_d = retired_q + 1'b1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes decode only the registered state; ir_wen alone looks at the live ack.
    always_comb begin
        imem_req = 1'b0;
        ir_wen   = 1'b0;
        dram_req = 1'b0;
        dram_we  = 1'b0;
        rf_wen   = 1'b0;
        pc_wen   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_wen   = imem_ack;
            end
            S_MEM: begin
                dram_req = 1'b1;
                dram_we  = mem_wr;
            end
            S_WB: begin
                rf_wen = rf_wen_in;
                pc_wen = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign phase   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer (CNT_W=4 so the retire counter wrap is reachable).
module tb_mc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_wen;
    logic       ins_illegal;
    logic       mem_rd;
    logic       mem_wr;
    logic       rf_wen_in;
    logic       dram_req;
    logic       dram_we;
    logic       dram_ack;
    logic       rf_wen;
    logic       pc_wen;
    logic [2:0] phase;
    logic       halted;
    logic       fault;
    logic [3:0] retired;

    int n_assert = 0;
    int n_fail   = 0;

    mc_sequencer #(.CNT_W(4), .TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .ir_wen      (ir_wen),
        .ins_illegal (ins_illegal),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .rf_wen_in   (rf_wen_in),
        .dram_req    (dram_req),
        .dram_we     (dram_we),
        .dram_ack    (dram_ack),
        .rf_wen      (rf_wen),
        .pc_wen      (pc_wen),
        .phase       (phase),
        .halted      (halted),
        .fault       (fault),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; ins_illegal = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; rf_wen_in = 1'b0; dram_ack = 1'b0;
        #12;
        check("rst_phase", 32'(phase), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_strobes", {26'd0, imem_req, ir_wen, dram_req, dram_we, rf_wen, pc_wen}, 0);
        @(negedge clk) rst_n = 1'b1;

        // ADD, zero-wait fetch
        run = 1'b1; imem_ack = 1'b1; rf_wen_in = 1'b1;
        #1;
        check("idle_phase", 32'(phase), 0);
        check("idle_ir_wen", 32'(ir_wen), 0);
        tick();
        check("add_fetch_phase", 32'(phase), 1);
        check("add_fetch_req", 32'(imem_req), 1);
        check("add_fetch_ir_wen", 32'(ir_wen), 1);
        tick();
        check("add_decode_phase", 32'(phase), 2);
        check("add_decode_ir_wen", 32'(ir_wen), 0);
        check("add_decode_rfpc", {30'd0, rf_wen, pc_wen}, 0);
        tick();
        check("add_exec_phase", 32'(phase), 3);
        check("add_exec_rfpc", {30'd0, rf_wen, pc_wen}, 0);
        tick();
        check("add_wb_phase", 32'(phase), 5);
        check("add_wb_rfpc", {30'd0, rf_wen, pc_wen}, 3);
        check("add_wb_retired", 32'(retired), 0);
        tick();
        check("add_next_phase", 32'(phase), 1);
        check("add_retired", 32'(retired), 1);

        // LW with dram_ack on the 4th MEM cycle
        mem_rd = 1'b1;
        tick();
        tick();
        check("lw_exec_phase", 32'(phase), 3);
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lw_mem_wait%0d", i), {29'd0, phase == 3'd4, dram_req, dram_we}, 3'b110);
            tick();
        end
        dram_ack = 1'b1;
        #1;
        check("lw_mem_ack", {29'd0, phase == 3'd4, dram_req, dram_we}, 3'b110);
        tick();
        dram_ack = 1'b0;
        #1;
        check("lw_wb_phase", 32'(phase), 5);
        check("lw_wb_rf_wen", 32'(rf_wen), 1);
        check("lw_wb_dram_req", 32'(dram_req), 0);
        tick();
        check("lw_retired", 32'(retired), 2);

        // SW with one fetch wait
        mem_rd = 1'b0; mem_wr = 1'b1; rf_wen_in = 1'b0; imem_ack = 1'b0;
        #1;
        check("sw_fetch_wait_ir_wen", 32'(ir_wen), 0);
        tick();
        check("sw_fetch_wait_phase", 32'(phase), 1);
        imem_ack = 1'b1;
        #1;
        check("sw_fetch_ir_wen", 32'(ir_wen), 1);
        tick();
        tick();
        tick();
        check("sw_mem_we", {30'd0, dram_req, dram_we}, 3);
        dram_ack = 1'b1;
        tick();
        dram_ack = 1'b0;
        #1;
        check("sw_wb", {28'd0, phase == 3'd5, rf_wen, pc_wen, dram_we}, 4'b1010);
        tick();
        check("sw_retired", 32'(retired), 3);

        // ADD with run dropped in EXEC
        mem_wr = 1'b0; rf_wen_in = 1'b1;
        tick();
        tick();
        check("drop_exec_phase", 32'(phase), 3);
        run = 1'b0;
        tick();
        check("drop_wb", {28'd0, phase == 3'd5, pc_wen, rf_wen, 1'b0}, 4'b1110);
        tick();
        check("drop_idle_phase", 32'(phase), 0);
        check("drop_retired", 32'(retired), 4);
        tick();
        check("drop_idle_stay", 32'(phase), 0);
        run = 1'b1;
        tick();
        check("rerun_fetch", 32'(phase), 1);

        // Illegal instruction halts
        ins_illegal = 1'b1;
        tick();
        check("ill_decode", 32'(phase), 2);
        tick();
        check("ill_halt_phase", 32'(phase), 6);
        check("ill_halted", 32'(halted), 1);
        check("ill_no_pc_wen", 32'(pc_wen), 0);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        check("ill_sticky", 32'(phase), 6);
        check("ill_retired", 32'(retired), 4);
        check("ill_quiet", {28'd0, imem_req, dram_req, rf_wen, pc_wen}, 0);
        rst_n = 1'b0;
        #1;
        check("ill_rst_phase", 32'(phase), 0);
        check("ill_rst_retired", 32'(retired), 0);
        check("ill_rst_halted", 32'(halted), 0);

        // Asynchronous reset in the middle of a store
        ins_illegal = 1'b0; mem_wr = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("arst_mem_we", {30'd0, dram_req, dram_we}, 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_drop", {29'd0, dram_req, dram_we, phase != 3'd0}, 0);
        check("arst_retired", 32'(retired), 0);

        // Retire counter wrap with 4-bit counter
        mem_wr = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int n = 0; n < 15; n++) begin
            repeat (4) tick();
        end
        check("wrap_pre", 32'(retired), 15);
        check("wrap_pre_phase", 32'(phase), 1);
        repeat (4) tick();
        check("wrap_zero", 32'(retired), 0);

        // Fetch handshake with ack withheld
        rst_n = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("to_fetch", 32'(phase), 1);
`ifdef SEQ_TIMEOUT_EN
        repeat (3) tick();
        check("to_wait4", 32'(phase), 1);
        check("to_no_fault_yet", 32'(fault), 0);
        tick();
        check("to_halt", 32'(phase), 6);
        check("to_fault", 32'(fault), 1);
        check("to_halted", 32'(halted), 1);
        rst_n = 1'b0;
        #1;
        check("to_rst_fault", 32'(fault), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        repeat (3) tick();
        imem_ack = 1'b1;
        #1;
        check("to_late_ir_wen", 32'(ir_wen), 1);
        tick();
        check("to_late_decode", 32'(phase), 2);
        check("to_late_fault", 32'(fault), 0);
`else
        repeat (20) tick();
        check("nto_still_fetch", 32'(phase), 1);
        check("nto_fault", 32'(fault), 0);
        imem_ack = 1'b1;
        tick();
        check("nto_decode", 32'(phase), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle phase controller for the miniRV core.
- Steps one instruction through FETCH, DECODE, EXEC, MEM and WB using a shared instruction/data memory port.
- Gates the combinational decoder's write enables (register file, DRAM) so they fire only in the correct phase.
- Sits between the decoder and the PC, IR, register file and memory interface; counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 16, wait-cycle limit for a memory handshake (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue execution; sampled only at instruction boundaries.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction valid this cycle.
- ir_wen  out  1  load the instruction register.
- ins_illegal  in  1  decoder reports an illegal instruction (opcode 0000000).
- mem_rd  in  1  decoded load (wb_sel==2).
- mem_wr  in  1  decoded store (decoder dram_wen).
- rf_wen_in  in  1  decoder rf_wen.
- dram_req  out  1  data memory request.
- dram_we  out  1  data memory write strobe.
- dram_ack  in  1  data access complete.
- rf_wen  out  1  gated register-file write enable.
- pc_wen  out  1  PC update strobe.
- phase  out  3  current state encoding.
- halted  out  1  sequencer stopped.
- fault  out  1  handshake timeout occurred.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-low on rst_n.
- Reset values: phase=IDLE, retired=0, halted=0, fault=0, all strobes 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Output timing:
  - Strobes are decoded from the registered state.
  - ir_wen is the only Mealy output: ir_wen = (phase==FETCH) & imem_ack.
- IDLE:
  - run=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1 throughout.
  - imem_ack in the same cycle as the first request cycle is legal (zero wait).
  - On ack: ir_wen=1 that cycle, then -> DECODE.
- DECODE: one cycle.
  - ins_illegal=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC: one cycle.
  - mem_rd or mem_wr -> MEM.
  - Otherwise -> WB.
  - mem_rd and mem_wr both set is treated as a store.
- MEM:
  - dram_req=1 and dram_we=mem_wr, both held until dram_ack.
  - On ack -> WB.
- WB: one cycle.
  - rf_wen=rf_wen_in and pc_wen=1.
  - retired increments by 1 and wraps from all-ones to 0.
  - Then run=1 -> FETCH, run=0 -> IDLE.
- HALT:
  - Sticky until rst_n; halted=1.
  - No strobes, no requests; run is ignored.
- rf_wen, dram_we and pc_wen are never asserted outside WB/MEM; this holds even if decoder inputs change mid-instruction.
- imem_ack outside FETCH and dram_ack outside MEM are ignored.
- run dropping mid-instruction does not abort: the current instruction completes through WB, then the sequencer enters IDLE.
- Asynchronous reset mid-handshake drops req/we immediately; no partial retire is counted.
- Decoder inputs are sampled combinationally from the IR; the IR must be stable from DECODE through WB.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - If it reaches TIMEOUT_CYCLES with no ack -> HALT with fault=1 (sticky).
  - An ack arriving on the limit cycle wins over the timeout.
- Undefined:
  - No counter; FETCH and MEM wait indefinitely.
  - fault is tied to 0.

Test Plan:
- Reset, run=1, ADD with zero-wait acks -> phases 1,2,3,5,1; ir_wen one cycle; rf_wen=1 and pc_wen=1 only in WB; retired=1.
- LW with dram_ack delayed 3 cycles -> dram_req high 4 cycles, dram_we=0, then WB with rf_wen=1; SW -> dram_we=1 in MEM, rf_wen=0 in WB.
- Drop run during EXEC of a 2nd instruction -> completes WB, retired=2, phase=0; raise run -> FETCH next cycle.
- ins_illegal=1 in DECODE -> HALT (phase=6), halted=1, no pc_wen; run toggling has no effect; rst_n low -> IDLE, retired=0.
- Preset retired to all-ones by running 2^CNT_W-1 instructions (CNT_W=4 build) -> next retire reads 0.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_ack held 0 -> HALT with fault=1 after 4 wait cycles; ack on 4th cycle -> DECODE, fault=0.
